enemy_wave_controller: RTL and testbench

Sequences the group of enemy movement units across a game session. It spawns enemies one at a time by pulsing each unit's location restart, tracks which enemies are still alive from per-enemy hit flags, and detects when a wave is cleared. It then waits for a gap, raises the shared enemy speed word and starts the next wave. Sits between the game-control logic and the array of enemy movement/collision units; its speed output drives every unit's enemySpeed input (fixed-point, 64 = 1 px/frame).

---
 rtl/enemy_pkg.sv | 15 +
 rtl/frame_down_counter.sv | 28 ++
 rtl/enemy_wave_controller.sv | 154 +++++++++++++++
 tb/tb_enemy_wave_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared types and constants for the enemy wave sequencer
package enemy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        PLAY,
        WAVE_GAP,
        WON
    } state_t;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int SPEED_W                = 11;

endpackage

// File: rtl/frame_down_counter.sv
// rtl/frame_down_counter.sv - loadable down-counter that steps on frame ticks
module frame_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load wins over a coincident tick; the count parks at zero.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/enemy_wave_controller.sv
// rtl/enemy_wave_controller.sv - spawns enemies, tracks live ones, steps waves and speed
module enemy_wave_controller
    import enemy_pkg::*;
#(
    parameter int NUM_ENEMIES      = 4,
    parameter int BASE_SPEED       = FIXED_POINT_MULTIPLIER,
    parameter int SPEED_STEP       = 16,
    parameter int MAX_SPEED        = 256,
    parameter int SPAWN_GAP_FRAMES = 30,
    parameter int WAVE_GAP_FRAMES  = 120,
    parameter int MAX_WAVE         = 7
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   startGame,
    input  logic                   pause,
    input  logic                   playerDead,
    input  logic [NUM_ENEMIES-1:0] enemyHit,
    output logic [NUM_ENEMIES-1:0] restartLoc,
    output logic [NUM_ENEMIES-1:0] enemyActive,
    output logic [SPEED_W-1:0]     enemySpeed,
    output logic [2:0]             waveNum,
    output logic                   waveCleared,
    output logic                   gameWon
);

    localparam int GAP_MAX = (SPAWN_GAP_FRAMES > WAVE_GAP_FRAMES) ? SPAWN_GAP_FRAMES : WAVE_GAP_FRAMES;
    localparam int CNT_W   = $clog2(GAP_MAX + 1);
    localparam int IDX_W   = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;

    localparam logic [CNT_W-1:0]   SPAWN_RELOAD = CNT_W'(SPAWN_GAP_FRAMES - 1);
    localparam logic [CNT_W-1:0]   WAVE_RELOAD  = CNT_W'(WAVE_GAP_FRAMES - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_ENEMIES - 1);
    localparam logic [SPEED_W-1:0] BASE_SPD     = SPEED_W'(BASE_SPEED);

    state_t                   state;
    logic [IDX_W-1:0]         spawn_idx;
    logic                     tick;
    logic                     cnt_load;
    logic [CNT_W-1:0]         cnt_value;
    logic                     cnt_zero;
    logic [NUM_ENEMIES-1:0]   spawn_mask;
    logic [NUM_ENEMIES-1:0]   active_hit;
    logic [SPEED_W:0]         speed_sum;
    logic [SPEED_W-1:0]       speed_next;

    assign tick       = startOfFrame && !pause;
    assign spawn_mask = NUM_ENEMIES'(1) << spawn_idx;
    assign active_hit = enemyActive & ~enemyHit;
    assign speed_sum  = {1'b0, enemySpeed} + (SPEED_W + 1)'(SPEED_STEP);
    assign speed_next = (speed_sum > (SPEED_W + 1)'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED)
                                                                : speed_sum[SPEED_W-1:0];

    // One counter times both the spawn spacing and the gap between waves.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = '0;
        case (state)
            IDLE, WON: cnt_load = startGame;
            SPAWN: begin
                if (tick && cnt_zero) begin
                    cnt_load  = 1'b1;
                    cnt_value = SPAWN_RELOAD;
                end
            end
            PLAY: begin
                if (enemyActive == '0) begin
                    cnt_load  = 1'b1;
                    cnt_value = WAVE_RELOAD;
                end
            end
            WAVE_GAP: cnt_load = cnt_zero;
            default: cnt_load = 1'b0;
        endcase
    end

    frame_down_counter #(.WIDTH(CNT_W)) u_gap_counter (
        .clk       (clk),
        .resetN    (resetN),
        .tick      (tick),
        .load      (cnt_load),
        .load_value(cnt_value),
        .zero      (cnt_zero)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            spawn_idx   <= '0;
            restartLoc  <= '0;
            enemyActive <= '0;
            enemySpeed  <= BASE_SPD;
            waveNum     <= '0;
            waveCleared <= 1'b0;
            gameWon     <= 1'b0;
        end else begin
            restartLoc  <= '0;
            waveCleared <= 1'b0;
            case (state)
                IDLE, WON: begin
                    enemyActive <= '0;
                    if (startGame && !playerDead) begin
                        state      <= SPAWN;
                        spawn_idx  <= '0;
                        waveNum    <= '0;
                        enemySpeed <= BASE_SPD;
                        gameWon    <= 1'b0;
                    end
                end
                SPAWN, PLAY, WAVE_GAP: begin
                    if (playerDead) begin
                        state       <= IDLE;
                        enemyActive <= '0;
                    end else if (state == SPAWN) begin
                        if (tick && cnt_zero) begin
                            restartLoc  <= spawn_mask;
                            enemyActive <= active_hit | spawn_mask;
                            if (spawn_idx == LAST_IDX) begin
                                state     <= PLAY;
                                spawn_idx <= '0;
                            end else begin
                                spawn_idx <= spawn_idx + IDX_W'(1);
                            end
                        end else begin
                            enemyActive <= active_hit;
                        end
                    end else if (state == PLAY) begin
                        enemyActive <= active_hit;
                        if (enemyActive == '0) begin
                            waveCleared <= 1'b1;
                            if (waveNum == 3'(MAX_WAVE)) begin
                                state   <= WON;
                                gameWon <= 1'b1;
                            end else begin
                                state <= WAVE_GAP;
                            end
                        end
                    end else begin
                        enemyActive <= active_hit;
                        if (cnt_zero) begin
                            state      <= SPAWN;
                            spawn_idx  <= '0;
                            waveNum    <= waveNum + 3'd1;
                            enemySpeed <= speed_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_wave_controller.sv
// tb/tb_enemy_wave_controller.sv - scoreboard bench for enemy_wave_controller
module tb_enemy_wave_controller;
    import enemy_pkg::*;

    logic        clk = 1'b0;
    logic        resetN, startOfFrame, startGame, pause, playerDead;
    logic [3:0]  enemyHit, restartLoc, enemyActive;
    logic [10:0] enemySpeed;
    logic [2:0]  waveNum;
    logic        waveCleared, gameWon;

    logic        startGame2, playerDead2;
    logic [3:0]  enemyHit2, restartLoc2, enemyActive2;
    logic [10:0] enemySpeed2;
    logic [2:0]  waveNum2;
    logic        waveCleared2, gameWon2;

    typedef struct {
        logic [3:0]  mask;
        int          tick;
        logic [2:0]  wave;
        logic [10:0] speed;
    } spawn_t;

    spawn_t spawn_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     tick_cnt = 0;
    int     frame_phase = 0;
    int     base;

    always #5 clk = ~clk;

    enemy_wave_controller dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
        .pause(pause), .playerDead(playerDead), .enemyHit(enemyHit), .restartLoc(restartLoc),
        .enemyActive(enemyActive), .enemySpeed(enemySpeed), .waveNum(waveNum),
        .waveCleared(waveCleared), .gameWon(gameWon)
    );

    enemy_wave_controller #(
        .BASE_SPEED(250), .SPAWN_GAP_FRAMES(2), .WAVE_GAP_FRAMES(3)
    ) dut_sat (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame2),
        .pause(pause), .playerDead(playerDead2), .enemyHit(enemyHit2), .restartLoc(restartLoc2),
        .enemyActive(enemyActive2), .enemySpeed(enemySpeed2), .waveNum(waveNum2),
        .waveCleared(waveCleared2), .gameWon(gameWon2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] wave_speed(input int w);
        int s = 64 + 16 * w;
        return (s > 256) ? 11'd256 : 11'(s);
    endfunction

    task automatic push_wave(input int first_tick, input int w);
        for (int i = 0; i < 4; i++) begin
            spawn_t e;
            e.mask  = 4'(1 << i);
            e.tick  = first_tick + 30 * i;
            e.wave  = 3'(w);
            e.speed = wave_speed(w);
            spawn_q.push_back(e);
        end
    endtask

    task automatic monitor();
        spawn_t e;
        if (restartLoc != 4'h0) begin
            if (spawn_q.size() == 0) begin
                check("spawn_unexpected", 32'(restartLoc), 32'h0);
            end else begin
                e = spawn_q.pop_front();
                check("spawn_mask", 32'(restartLoc), 32'(e.mask));
                check("spawn_tick", 32'(tick_cnt), 32'(e.tick));
                check("spawn_wave", 32'(waveNum), 32'(e.wave));
                check("spawn_speed", 32'(enemySpeed), 32'(e.speed));
            end
        end
    endtask

    // One clock: sample #1 after the edge, clear pulses, schedule the next frame tick.
    task automatic cyc();
        bit t = startOfFrame && !pause;
        @(posedge clk);
        #1;
        if (t) tick_cnt++;
        startGame  = 1'b0;
        playerDead = 1'b0;
        enemyHit   = 4'h0;
        startGame2 = 1'b0;
        enemyHit2  = 4'h0;
        monitor();
        frame_phase++;
        startOfFrame = (frame_phase % 10 == 0);
    endtask

    task automatic wait_spawns(input int budget);
        for (int n = 0; n < budget && spawn_q.size() != 0; n++) cyc();
        check("spawn_drain", 32'(spawn_q.size()), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_restart"}, 32'(restartLoc), 32'h0);
        check({tag, "_active"}, 32'(enemyActive), 32'h0);
        check({tag, "_speed"}, 32'(enemySpeed), 32'd64);
        check({tag, "_wave"}, 32'(waveNum), 32'h0);
        check({tag, "_cleared"}, 32'(waveCleared), 32'h0);
        check({tag, "_won"}, 32'(gameWon), 32'h0);
        check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; startGame = 1'b0; pause = 1'b0;
        playerDead = 1'b0; enemyHit = 4'h0;
        startGame2 = 1'b0; playerDead2 = 1'b0; enemyHit2 = 4'h0;
        repeat (3) cyc();
        check_reset_outputs("rst");
        resetN = 1'b1;
        cyc();

        // Speed saturation on a fast, high-base-speed instance.
        startGame2 = 1'b1;
        cyc();
        for (int n = 0; n < 300 && enemyActive2 != 4'hF; n++) cyc();
        check("sat_active", 32'(enemyActive2), 32'hF);
        enemyHit2 = 4'hF;
        cyc();
        for (int n = 0; n < 300 && waveNum2 != 3'd1; n++) cyc();
        check("sat_wave", 32'(waveNum2), 32'd1);
        check("sat_speed", 32'(enemySpeed2), 32'd256);

        // Wave 0 spawning.
        startGame = 1'b1;
        cyc();
        base = tick_cnt;
        push_wave(base + 1, 0);
        wait_spawns(1200);
        cyc();
        check("w0_active", 32'(enemyActive), 32'hF);
        check("w0_state", 32'(dut.state), 32'(PLAY));
        check("w0_speed", 32'(enemySpeed), 32'd64);

        // Partial hits, a hit on a dead enemy, then the clearing hit.
        enemyHit = 4'b0011;
        cyc();
        check("hit1_active", 32'(enemyActive), 32'b1100);
        check("hit1_cleared", 32'(waveCleared), 32'h0);
        enemyHit = 4'b0001;
        cyc();
        check("dead_hit_active", 32'(enemyActive), 32'b1100);
        enemyHit = 4'b1100;
        cyc();
        check("hit2_active", 32'(enemyActive), 32'h0);
        check("hit2_cleared", 32'(waveCleared), 32'h0);
        cyc();
        check("clear_pulse", 32'(waveCleared), 32'h1);
        check("clear_state", 32'(dut.state), 32'(WAVE_GAP));
        base = tick_cnt;
        push_wave(base + 120, 1);
        cyc();
        check("clear_one_cycle", 32'(waveCleared), 32'h0);

        // Pause 50 frames in the gap; the gap length counts only unpaused frames.
        repeat (300) cyc();
        pause = 1'b1;
        repeat (500) cyc();
        check("gap_paused_wave", 32'(waveNum), 32'd0);
        pause = 1'b0;
        wait_spawns(3000);

        enemyHit = 4'b0001;
        pause = 1'b1;
        cyc();
        check("pause_hit_active", 32'(enemyActive), 32'b1110);
        pause = 1'b0;

        for (int w = 1; w <= 7; w++) begin
            enemyHit = 4'hF;
            cyc();
            check("wave_hit_active", 32'(enemyActive), 32'h0);
            cyc();
            check("wave_cleared", 32'(waveCleared), 32'h1);
            if (w < 7) begin
                base = tick_cnt;
                push_wave(base + 120, w + 1);
                wait_spawns(3000);
            end else begin
                check("won_flag", 32'(gameWon), 32'h1);
                check("won_state", 32'(dut.state), 32'(WON));
            end
        end
        repeat (1500) cyc();
        check("won_hold", 32'(gameWon), 32'h1);
        check("won_speed", 32'(enemySpeed), 32'(wave_speed(7)));

        // playerDead lands on the tick that would spawn enemy 2.
        startGame = 1'b1;
        cyc();
        check("restart_won", 32'(gameWon), 32'h0);
        base = tick_cnt;
        spawn_q.push_back('{4'b0001, base + 1, 3'd0, 11'd64});
        spawn_q.push_back('{4'b0010, base + 31, 3'd0, 11'd64});
        for (int n = 0; n < 1000 && !(startOfFrame && tick_cnt == base + 60); n++) cyc();
        check("pd_align", 32'(tick_cnt), 32'(base + 60));
        playerDead = 1'b1;
        cyc();
        check("pd_restart", 32'(restartLoc), 32'h0);
        check("pd_active", 32'(enemyActive), 32'h0);
        check("pd_state", 32'(dut.state), 32'(IDLE));
        check("pd_queue", 32'(spawn_q.size()), 32'h0);
        repeat (100) cyc();

        startGame = 1'b1;
        cyc();
        check("regame_wave", 32'(waveNum), 32'h0);
        check("regame_speed", 32'(enemySpeed), 32'd64);
        base = tick_cnt;
        push_wave(base + 1, 0);
        for (int n = 0; n < 100 && spawn_q.size() != 3; n++) cyc();
        check("regame_first", 32'(spawn_q.size()), 32'd3);

        // Asynchronous reset mid-SPAWN.
        #3;
        resetN = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        spawn_q.delete();
        repeat (3) cyc();
        resetN = 1'b1;
        repeat (400) cyc();
        check("post_rst_state", 32'(dut.state), 32'(IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
